// File: rtl/sort_pkg.sv
// Shared types and helpers for the RAM bubble-sort sequencer.
package sort_pkg;

  // Sequencer states; every state other than IDLE owns the RAM ports.
  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    LOAD,
    SCAN,
    FLUSH,
    DONE
  } sort_state_e;

  // Address width for a RAM of the given depth (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sort_minmax.sv
// Compare-and-order step of one bubble pass: lo_o is the value that settles at
// address k-1, hi_o is the value carried forward as the new held element.
module sort_minmax #(
  parameter int width_p      = 8,
  parameter bit descending_p = 1'b0
) (
  input  logic [width_p-1:0] held_i,
  input  logic [width_p-1:0] cur_i,
  output logic [width_p-1:0] lo_o,
  output logic [width_p-1:0] hi_o,
  output logic               swap_o
);

  // Strict compare so equal keys never swap and the sort stays stable.
  always_comb begin
    swap_o = descending_p ? (held_i < cur_i) : (held_i > cur_i);
    lo_o   = swap_o ? cur_i  : held_i;
    hi_o   = swap_o ? held_i : cur_i;
  end

endmodule

// File: rtl/ram_bubble_sort_ctrl.sv
// In-place bubble-sort sequencer for a 1-read/1-write synchronous RAM.
// Idle: host traffic passes straight through. Busy: this block owns the RAM.
module ram_bubble_sort_ctrl
  import sort_pkg::*;
#(
  parameter int   width_p      = 8,
  parameter int   depth_p      = 512,
  parameter bit   descending_p = 1'b0,
  localparam int  aw           = addr_width(depth_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [aw:0]        len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [aw-1:0]      passes_o,
  input  logic               host_wr_valid_i,
  input  logic [aw-1:0]      host_wr_addr_i,
  input  logic [width_p-1:0] host_wr_data_i,
  input  logic               host_rd_valid_i,
  input  logic [aw-1:0]      host_rd_addr_i,
  output logic [width_p-1:0] host_rd_data_o,
  output logic               ram_wr_valid_o,
  output logic [aw-1:0]      ram_wr_addr_o,
  output logic [width_p-1:0] ram_wr_data_o,
  output logic               ram_rd_valid_o,
  output logic [aw-1:0]      ram_rd_addr_o,
  input  logic [width_p-1:0] ram_rd_data_i
);

  sort_state_e        state_q, state_d;
  logic [aw-1:0]      limit_q, limit_d;
  logic [aw-1:0]      k_q, k_d;
  logic [aw-1:0]      passes_q, passes_d;
  logic [width_p-1:0] held_q, held_d;
  logic               swapped_q, swapped_d;

  logic [width_p-1:0] cmp_lo, cmp_hi;
  logic               cmp_swap;

  sort_minmax #(
    .width_p      (width_p),
    .descending_p (descending_p)
  ) u_minmax (
    .held_i (held_q),
    .cur_i  (ram_rd_data_i),
    .lo_o   (cmp_lo),
    .hi_o   (cmp_hi),
    .swap_o (cmp_swap)
  );

  assign host_rd_data_o = ram_rd_data_i;
  assign passes_o       = passes_q;

  // State and datapath registers; reset abandons any sort in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      limit_q   <= '0;
      k_q       <= '0;
      passes_q  <= '0;
      held_q    <= '0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      k_q       <= k_d;
      passes_q  <= passes_d;
      held_q    <= held_d;
      swapped_q <= swapped_d;
    end
  end

  // Next-state and datapath updates: one pass is PRIME, LOAD, limit SCANs, FLUSH.
  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    k_d       = k_q;
    passes_d  = passes_q;
    held_d    = held_q;
    swapped_d = swapped_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          passes_d = '0;
          if (len_i < (aw+1)'(2)) begin
            state_d = DONE;
          end else begin
            limit_d = aw'(len_i - (aw+1)'(1));
            state_d = PRIME;
          end
        end
      end
      PRIME: begin
        swapped_d = 1'b0;
        state_d   = LOAD;
      end
      LOAD: begin
        held_d  = ram_rd_data_i;
        k_d     = aw'(1);
        state_d = SCAN;
      end
      SCAN: begin
        held_d    = cmp_hi;
        swapped_d = swapped_q | cmp_swap;
        if (k_q < limit_q) begin
          k_d = k_q + aw'(1);
        end else begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        passes_d = passes_q + aw'(1);
        if (!swapped_q || (limit_q == aw'(1))) begin
          state_d = DONE;
        end else begin
          limit_d = limit_q - aw'(1);
          state_d = PRIME;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM port mux: host passthrough when idle, sequencer accesses when busy.
  always_comb begin
    busy_o         = (state_q != IDLE);
    done_o         = (state_q == DONE);
    ram_wr_valid_o = 1'b0;
    ram_wr_addr_o  = '0;
    ram_wr_data_o  = '0;
    ram_rd_valid_o = 1'b0;
    ram_rd_addr_o  = '0;
    case (state_q)
      IDLE: begin
        ram_wr_valid_o = host_wr_valid_i;
        ram_wr_addr_o  = host_wr_addr_i;
        ram_wr_data_o  = host_wr_data_i;
        ram_rd_valid_o = host_rd_valid_i;
        ram_rd_addr_o  = host_rd_addr_i;
      end
      PRIME: begin
        ram_rd_valid_o = 1'b1;
        ram_rd_addr_o  = '0;
      end
      LOAD: begin
        ram_rd_valid_o = 1'b1;
        ram_rd_addr_o  = aw'(1);
      end
      SCAN: begin
        ram_wr_valid_o = 1'b1;
        ram_wr_addr_o  = k_q - aw'(1);
        ram_wr_data_o  = cmp_lo;
        if (k_q < limit_q) begin
          ram_rd_valid_o = 1'b1;
          ram_rd_addr_o  = k_q + aw'(1);
        end
      end
      FLUSH: begin
        ram_wr_valid_o = 1'b1;
        ram_wr_addr_o  = limit_q;
        ram_wr_data_o  = held_q;
      end
      default: begin
      end
    endcase
    if (reset_i) begin
      ram_wr_valid_o = 1'b0;
      ram_rd_valid_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_bubble_sort_ctrl.sv
// Bench for ram_bubble_sort_ctrl: an ascending instance (depth 16) and a
// descending instance (depth 8), each attached to a behavioural 1r1w RAM.
module tb_ram_bubble_sort_ctrl;

  localparam int W   = 8;
  localparam int DA  = 16;
  localparam int AWA = 4;
  localparam int DD  = 8;
  localparam int AWD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic           startA, busyA, doneA;
  logic [AWA:0]   lenA;
  logic [AWA-1:0] passesA;
  logic           hWrVA, hRdVA, rWrVA, rRdVA;
  logic [AWA-1:0] hWrAA, hRdAA, rWrAA, rRdAA;
  logic [W-1:0]   hWrDA, hRdDA, rWrDA, rRdDA;
  logic [W-1:0]   memA [DA];

  logic           startD, busyD, doneD;
  logic [AWD:0]   lenD;
  logic [AWD-1:0] passesD;
  logic           hWrVD, hRdVD, rWrVD, rRdVD;
  logic [AWD-1:0] hWrAD, hRdAD, rWrAD, rRdAD;
  logic [W-1:0]   hWrDD, hRdDD, rWrDD, rRdDD;
  logic [W-1:0]   memD [DD];

  int checks = 0;
  int errors = 0;
  int expQ[$];
  int mdl[DA];
  int shadowD[DD];
  int curLenA = 0;
  int curLenD = 0;
  bit sawAccessA = 1'b0;

  ram_bubble_sort_ctrl #(.width_p(W), .depth_p(DA), .descending_p(1'b0)) dutA (
    .clk_i(clk), .reset_i(reset), .start_i(startA), .len_i(lenA),
    .busy_o(busyA), .done_o(doneA), .passes_o(passesA),
    .host_wr_valid_i(hWrVA), .host_wr_addr_i(hWrAA), .host_wr_data_i(hWrDA),
    .host_rd_valid_i(hRdVA), .host_rd_addr_i(hRdAA), .host_rd_data_o(hRdDA),
    .ram_wr_valid_o(rWrVA), .ram_wr_addr_o(rWrAA), .ram_wr_data_o(rWrDA),
    .ram_rd_valid_o(rRdVA), .ram_rd_addr_o(rRdAA), .ram_rd_data_i(rRdDA)
  );

  ram_bubble_sort_ctrl #(.width_p(W), .depth_p(DD), .descending_p(1'b1)) dutD (
    .clk_i(clk), .reset_i(reset), .start_i(startD), .len_i(lenD),
    .busy_o(busyD), .done_o(doneD), .passes_o(passesD),
    .host_wr_valid_i(hWrVD), .host_wr_addr_i(hWrAD), .host_wr_data_i(hWrDD),
    .host_rd_valid_i(hRdVD), .host_rd_addr_i(hRdAD), .host_rd_data_o(hRdDD),
    .ram_wr_valid_o(rWrVD), .ram_wr_addr_o(rWrAD), .ram_wr_data_o(rWrDD),
    .ram_rd_valid_o(rRdVD), .ram_rd_addr_o(rRdAD), .ram_rd_data_i(rRdDD)
  );

  // Behavioural RAMs with one-cycle registered read
  always @(posedge clk) begin
    if (rWrVA) memA[rWrAA] <= rWrDA;
    if (rRdVA) rRdDA <= memA[rRdAA];
    if (rWrVD) memD[rWrAD] <= rWrDD;
    if (rRdVD) rRdDD <= memD[rRdAD];
  end

  // Watch RAM traffic during sorts: no same-address read/write, no write outside [0,len)
  always @(negedge clk) begin
    if (!reset && busyA) begin
      if (rWrVA || rRdVA) sawAccessA = 1'b1;
      if (rWrVA && rRdVA) begin
        checks++;
        if (rWrAA === rRdAA) begin
          errors++;
          $display("[TB] FAIL collisionA addr=%0d", rWrAA);
        end
      end
      if (rWrVA) begin
        checks++;
        if (int'(rWrAA) >= curLenA) begin
          errors++;
          $display("[TB] FAIL boundsA write addr=%0d required below %0d", rWrAA, curLenA);
        end
      end
    end
    if (!reset && busyD && rWrVD) begin
      checks++;
      if ((rRdVD && rWrAD === rRdAD) || int'(rWrAD) >= curLenD) begin
        errors++;
        $display("[TB] FAIL trafficD wr=%0d rd=%0d len=%0d", rWrAD, rRdAD, curLenD);
      end
    end
  end

  // Reference bubble sort over mdl[0..n-1]; returns pass count and start-to-done latency
  task automatic modelSort(input int n, input bit desc, output int passes, output int cycles);
    int limit;
    int t;
    bit sw;
    passes = 0;
    cycles = 1;
    if (n < 2) return;
    limit = n - 1;
    forever begin
      sw = 1'b0;
      for (int i = 1; i <= limit; i++) begin
        if (desc ? (mdl[i-1] < mdl[i]) : (mdl[i-1] > mdl[i])) begin
          t = mdl[i-1]; mdl[i-1] = mdl[i]; mdl[i] = t;
          sw = 1'b1;
        end
      end
      passes++;
      cycles += limit + 3;
      if (!sw || limit == 1) break;
      limit--;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeA(input int addr, input int data);
    hWrVA = 1'b1; hWrAA = AWA'(addr); hWrDA = W'(data);
    step();
    hWrVA = 1'b0;
    mdl[addr] = data;
  endtask

  task automatic fillRandomA();
    for (int i = 0; i < DA; i++) writeA(i, int'($urandom_range(0, 255)));
  endtask

  task automatic unloadA(input string name);
    int exp;
    for (int i = 0; i < DA; i++) begin
      hRdVA = 1'b1; hRdAA = AWA'(i);
      step();
      exp = expQ.pop_front();
      checks++;
      if (hRdDA !== W'(exp)) begin
        errors++;
        $display("[TB] FAIL %s cell[%0d] got=%0d exp=%0d", name, i, hRdDA, exp);
      end
    end
    hRdVA = 1'b0;
  endtask

  // Start a sort on dutA, optionally with host noise while busy, and check timing and result
  task automatic runSortA(input int n, input bit noise, input string name, output int cycOut);
    int expPasses, expCycles, cyc;
    modelSort(n, 1'b0, expPasses, expCycles);
    for (int i = 0; i < DA; i++) expQ.push_back(mdl[i]);
    curLenA = n;
    sawAccessA = 1'b0;
    startA = 1'b1; lenA = (AWA+1)'(n);
    step();
    if (!noise) startA = 1'b0;
    cyc = 1;
    while (doneA !== 1'b1 && cyc < 2000) begin
      if (noise) begin
        hWrVA = 1'b1; hWrAA = AWA'(2); hWrDA = 8'hAA;
        startA = 1'b1; lenA = (AWA+1)'(2);
      end
      step();
      cyc++;
    end
    hWrVA = 1'b0; startA = 1'b0;
    cycOut = cyc;
    checks++;
    if (doneA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done timeout got=%b exp=1", name, doneA);
    end
    checks++;
    if (cyc != expCycles) begin
      errors++;
      $display("[TB] FAIL %s latency got=%0d exp=%0d", name, cyc, expCycles);
    end
    checks++;
    if (passesA !== AWA'(expPasses)) begin
      errors++;
      $display("[TB] FAIL %s passes got=%0d exp=%0d", name, passesA, expPasses);
    end
    if (n < 2) begin
      checks++;
      if (sawAccessA) begin
        errors++;
        $display("[TB] FAIL %s ram access got=1 exp=0", name);
      end
    end
    step();
    checks++;
    if (doneA !== 1'b0 || busyA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s after done got done=%b busy=%b exp 0/0", name, doneA, busyA);
    end
    unloadA(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    startA = 1'b0; lenA = '0; hWrVA = 1'b1; hWrAA = '0; hWrDA = '0; hRdVA = 1'b1; hRdAA = '0;
    startD = 1'b0; lenD = '0; hWrVD = 1'b0; hWrAD = '0; hWrDD = '0; hRdVD = 1'b0; hRdAD = '0;
    step(); step();
    checks++;
    if (busyA !== 1'b0 || doneA !== 1'b0 || passesA !== '0) begin
      errors++;
      $display("[TB] FAIL reset state got busy=%b done=%b passes=%0d exp 0/0/0", busyA, doneA, passesA);
    end
    checks++;
    if (rWrVA !== 1'b0 || rRdVA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset ram valids got wr=%b rd=%b exp 0/0", rWrVA, rRdVA);
    end
    hWrVA = 1'b0; hRdVA = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_example();
    int cyc;
    fillRandomA();
    writeA(0, 5); writeA(1, 3); writeA(2, 8); writeA(3, 1);
    runSortA(4, 1'b0, "example", cyc);
    checks++;
    if (passesA !== AWA'(3)) begin
      errors++;
      $display("[TB] FAIL example passes const got=%0d exp=3", passesA);
    end
  endtask

  task automatic test_sorted();
    int cyc;
    for (int i = 0; i < 5; i++) writeA(i, i + 1);
    runSortA(5, 1'b0, "sorted", cyc);
    checks++;
    if (cyc != 8 || passesA !== AWA'(1)) begin
      errors++;
      $display("[TB] FAIL sorted const got cyc=%0d passes=%0d exp 8/1", cyc, passesA);
    end
  endtask

  task automatic test_duplicates();
    int cyc;
    writeA(0, 7); writeA(1, 7); writeA(2, 2); writeA(3, 7);
    runSortA(4, 1'b0, "dups", cyc);
  endtask

  task automatic test_short_len();
    int cyc;
    fillRandomA();
    runSortA(0, 1'b0, "len0", cyc);
    runSortA(1, 1'b0, "len1", cyc);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    fillRandomA();
    runSortA(6, 1'b1, "busy", cyc);
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    fillRandomA();
    curLenA = 10;
    startA = 1'b1; lenA = (AWA+1)'(10);
    step();
    startA = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    #1;
    checks++;
    if (rWrVA !== 1'b0 || rRdVA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset valids got wr=%b rd=%b exp 0/0", rWrVA, rRdVA);
    end
    step();
    reset = 1'b0;
    checks++;
    if (busyA !== 1'b0 || doneA !== 1'b0 || passesA !== '0) begin
      errors++;
      $display("[TB] FAIL midreset state got busy=%b done=%b passes=%0d exp 0/0/0", busyA, doneA, passesA);
    end
    fillRandomA();
    for (int i = 0; i < DA; i++) expQ.push_back(mdl[i]);
    unloadA("passthru");
    runSortA(10, 1'b0, "aftereset", cyc);
  endtask

  task automatic test_random();
    int cyc;
    for (int r = 0; r < 6; r++) begin
      fillRandomA();
      runSortA(int'($urandom_range(2, DA)), 1'b0, "random", cyc);
    end
  endtask

  // Descending instance: load values, sort, unload and compare against the model
  task automatic runSortD(input int n, input string name);
    int expPasses, expCycles, cyc, exp;
    for (int i = 0; i < DD; i++) mdl[i] = shadowD[i];
    modelSort(n, 1'b1, expPasses, expCycles);
    for (int i = 0; i < DD; i++) begin
      expQ.push_back(mdl[i]);
      shadowD[i] = mdl[i];
    end
    curLenD = n;
    startD = 1'b1; lenD = (AWD+1)'(n);
    step();
    startD = 1'b0;
    cyc = 1;
    while (doneD !== 1'b1 && cyc < 2000) begin
      step();
      cyc++;
    end
    checks++;
    if (doneD !== 1'b1 || cyc != expCycles || passesD !== AWD'(expPasses)) begin
      errors++;
      $display("[TB] FAIL %s done/latency/passes got %b/%0d/%0d exp 1/%0d/%0d",
               name, doneD, cyc, passesD, expCycles, expPasses);
    end
    step();
    for (int i = 0; i < DD; i++) begin
      hRdVD = 1'b1; hRdAD = AWD'(i);
      step();
      exp = expQ.pop_front();
      checks++;
      if (hRdDD !== W'(exp)) begin
        errors++;
        $display("[TB] FAIL %s cell[%0d] got=%0d exp=%0d", name, i, hRdDD, exp);
      end
    end
    hRdVD = 1'b0;
  endtask

  task automatic writeD(input int addr, input int data);
    hWrVD = 1'b1; hWrAD = AWD'(addr); hWrDD = W'(data);
    step();
    hWrVD = 1'b0;
    shadowD[addr] = data;
  endtask

  task automatic test_descending();
    for (int i = 0; i < DD; i++) writeD(i, 8'h30 + i);
    writeD(0, 1); writeD(1, 9); writeD(2, 4);
    runSortD(3, "desc");
    for (int i = 0; i < DD; i++) writeD(i, int'($urandom_range(0, 255)));
    runSortD(DD, "descrand");
  endtask

  initial begin
    test_reset();
    test_example();
    test_sorted();
    test_duplicates();
    test_short_len();
    test_busy_ignore();
    test_reset_mid_scan();
    test_random();
    test_descending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
